// File: rtl/mxfp8_block_quantizer.sv
// BF16 -> MXFP8 block quantizer: buffers BLOCK BF16 values, derives a shared E8M0 scale
// from the largest exponent, then streams E4M3 elements. Optional macro: MXFP8_QUANT_RNE_EN.
module mxfp8_block_quantizer #(
    parameter int unsigned BLOCK = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [15:0] in_bf16_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [7:0]  out_scale_o,
    output logic [7:0]  out_elem_o,
    output logic        out_first_o,
    output logic        out_last_o
);
    localparam int unsigned CW = $clog2(BLOCK);
`ifdef MXFP8_QUANT_RNE_EN
    localparam bit RneEn = 1'b1;
`else
    localparam bit RneEn = 1'b0;
`endif

    typedef enum logic [1:0] {StFill, StScale, StDrain} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, idx_q, idx_d, idx_nxt;
    logic [7:0]    emax_q, emax_d;
    logic [7:0]    scale_q, scale_d, elem_q, elem_d, scale_calc, enc_s;
    logic          first_q, first_d, last_q, last_d;
    logic [15:0]   buf_q [BLOCK];
    logic [15:0]   enc_in;
    logic          buf_we;
    logic [7:0]    in_exp;

    function automatic logic [7:0] encode(input logic [15:0] v, input logic [7:0] s);
        logic              sign;
        logic [7:0]        ex;
        logic [6:0]        mant;
        logic signed [9:0] e;
        logic signed [9:0] sh;
        logic [2:0]        m;
        logic [3:0]        m4;
        logic              up;
        logic [15:0]       ext;
        logic [7:0]        r;
        sign = v[15];
        ex   = v[14:7];
        mant = v[6:0];
        e    = $signed({2'b00, ex}) - $signed({2'b00, s}) + 10'sd7;
        sh   = 10'sd1 - e;
        r    = {sign, 7'h00};
        m    = 3'd0;
        m4   = 4'd0;
        up   = 1'b0;
        ext  = 16'd0;
        if (ex == 8'h00) begin
            r = {sign, 7'h00};
        end else if (ex == 8'hFF) begin
            r = (mant != 7'd0) ? {sign, 7'h7F} : {sign, 7'h7E};
        end else if (e >= 10'sd1) begin
            m  = mant[6:4];
            up = RneEn && mant[3] && ((mant[2:0] != 3'd0) || m[0]);
            m4 = {1'b0, m} + {3'b000, up};
            if (m4[3]) begin
                e = e + 10'sd1;
            end
            m = m4[2:0];
            if (e > 10'sd15 || (e == 10'sd15 && m == 3'b111)) begin
                r = {sign, 7'h7E};
            end else begin
                r = {sign, e[3:0], m};
            end
        end else if (sh <= 10'sd9) begin
            // Hidden one at bit 15; fraction bits land in [14:12], guard [11], sticky below.
            ext = {1'b1, mant, 8'h00} >> sh[3:0];
            m   = ext[14:12];
            up  = RneEn && ext[11] && ((ext[10:0] != 11'd0) || m[0]);
            m4  = {1'b0, m} + {3'b000, up};
            r   = m4[3] ? {sign, 4'd1, 3'd0} : {sign, 4'd0, m4[2:0]};
        end
        return r;
    endfunction

    assign in_exp      = in_bf16_i[14:7];
    assign idx_nxt     = idx_q + 1'b1;
    assign scale_calc  = (emax_q > 8'd8) ? (emax_q - 8'd8) : 8'd0;
    assign enc_in      = (state_q == StScale) ? buf_q[0] : buf_q[idx_nxt];
    assign enc_s       = (state_q == StScale) ? scale_calc : scale_q;
    assign in_ready_o  = (state_q == StFill);
    assign out_valid_o = (state_q == StDrain);
    assign out_scale_o = scale_q;
    assign out_elem_o  = elem_q;
    assign out_first_o = first_q;
    assign out_last_o  = last_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        emax_d  = emax_q;
        scale_d = scale_q;
        elem_d  = elem_q;
        first_d = first_q;
        last_d  = last_q;
        buf_we  = 1'b0;
        if (clear_i) begin
            state_d = StFill;
            cnt_d   = '0;
            idx_d   = '0;
            emax_d  = 8'd0;
        end else begin
            unique case (state_q)
                StFill: begin
                    if (in_valid_i) begin
                        buf_we = 1'b1;
                        if (in_exp != 8'h00 && in_exp != 8'hFF && in_exp > emax_q) begin
                            emax_d = in_exp;
                        end
                        cnt_d = cnt_q + 1'b1;
                        if (cnt_q == CW'(BLOCK - 1)) begin
                            state_d = StScale;
                        end
                    end
                end
                StScale: begin
                    state_d = StDrain;
                    idx_d   = '0;
                    scale_d = scale_calc;
                    elem_d  = encode(enc_in, enc_s);
                    first_d = 1'b1;
                    last_d  = 1'b0;
                end
                StDrain: begin
                    if (out_ready_i) begin
                        if (idx_q == CW'(BLOCK - 1)) begin
                            state_d = StFill;
                            idx_d   = '0;
                            emax_d  = 8'd0;
                        end else begin
                            idx_d   = idx_nxt;
                            elem_d  = encode(enc_in, enc_s);
                            first_d = 1'b0;
                            last_d  = (idx_nxt == CW'(BLOCK - 1));
                        end
                    end
                end
                default: state_d = StFill;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFill;
            cnt_q   <= '0;
            idx_q   <= '0;
            emax_q  <= 8'd0;
            scale_q <= 8'd0;
            elem_q  <= 8'd0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            emax_q  <= emax_d;
            scale_q <= scale_d;
            elem_q  <= elem_d;
            first_q <= first_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BLOCK; i++) begin
                buf_q[i] <= 16'd0;
            end
        end else if (buf_we) begin
            buf_q[cnt_q] <= in_bf16_i;
        end
    end
endmodule

// File: tb/tb_mxfp8_block_quantizer.sv
// Directed bench for mxfp8_block_quantizer; honours MXFP8_QUANT_RNE_EN for rounding vectors.
module tb_mxfp8_block_quantizer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_bf16 = 16'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_scale, out_elem;
    logic        out_first, out_last;

    int n_chk = 0;
    int n_err = 0;
    logic [15:0] vin   [8];
    logic [7:0]  exp_e [8];
    logic [7:0]  rnd_e;

    mxfp8_block_quantizer #(.BLOCK(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (clear),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_bf16_i   (in_bf16),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_scale_o (out_scale),
        .out_elem_o  (out_elem),
        .out_first_o (out_first),
        .out_last_o  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        int t = 0;
        in_valid = 1'b1;
        in_bf16  = d;
        while (!in_ready && t < 50) begin
            step();
            t++;
        end
        chk("push_ready", {7'd0, in_ready}, 8'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_block(input string tag);
        for (int i = 0; i < 8; i++) begin
            push(vin[i]);
        end
        chk({tag, "_scale_state_rdy"}, {7'd0, in_ready}, 8'd0);
        chk({tag, "_scale_state_vld"}, {7'd0, out_valid}, 8'd0);
    endtask

    task automatic drain(input string tag, input int n, input int stall_at, input logic [7:0] sc);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            while (!out_valid && t < 50) begin
                step();
                t++;
            end
            chk($sformatf("%s_valid%0d", tag, i), {7'd0, out_valid}, 8'd1);
            chk($sformatf("%s_scale%0d", tag, i), out_scale, sc);
            chk($sformatf("%s_elem%0d", tag, i), out_elem, exp_e[i]);
            chk($sformatf("%s_first%0d", tag, i), {7'd0, out_first}, {7'd0, i == 0});
            chk($sformatf("%s_last%0d", tag, i), {7'd0, out_last}, {7'd0, i == 7});
            if (i == stall_at) begin
                for (int k = 0; k < 3; k++) begin
                    step();
                    chk($sformatf("%s_stall_vld%0d", tag, k), {7'd0, out_valid}, 8'd1);
                    chk($sformatf("%s_stall_elem%0d", tag, k), out_elem, exp_e[i]);
                    chk($sformatf("%s_stall_scale%0d", tag, k), out_scale, sc);
                    chk($sformatf("%s_stall_first%0d", tag, k), {7'd0, out_first}, 8'd0);
                    chk($sformatf("%s_stall_last%0d", tag, k), {7'd0, out_last}, 8'd0);
                end
            end
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        if (n == 8) begin
            chk({tag, "_post_rdy"}, {7'd0, in_ready}, 8'd1);
            chk({tag, "_post_vld"}, {7'd0, out_valid}, 8'd0);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, {7'd0, in_ready}, 8'd1);
        chk({tag, "_out_valid"}, {7'd0, out_valid}, 8'd0);
        chk({tag, "_scale"}, out_scale, 8'h00);
        chk({tag, "_elem"}, out_elem, 8'h00);
        chk({tag, "_first"}, {7'd0, out_first}, 8'd0);
        chk({tag, "_last"}, {7'd0, out_last}, 8'd0);
    endtask

    initial begin
`ifdef MXFP8_QUANT_RNE_EN
        rnd_e = 8'h7A;
`else
        rnd_e = 8'h79;
`endif
        #12;
        check_reset_values("reset");
        step();
        rst_n = 1'b1;
        step();

        // All ones: emax 127 -> scale 0x77, each element at exponent 15.
        vin   = '{16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80};
        exp_e = '{8'h78, 8'h78, 8'h78, 8'h78, 8'h78, 8'h78, 8'h78, 8'h78};
        send_block("ones");
        drain("ones", 8, -1, 8'h77);

        vin   = '{16'h4040, 16'h3F80, 16'hBF00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        exp_e = '{8'h7C, 8'h70, 8'hE8, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_block("mixed");
        drain("mixed", 8, -1, 8'h78);

        vin   = '{16'h3F80, 16'h3F98, 16'h3F98, 16'h3F98, 16'h3F98, 16'h3F98, 16'h3F98, 16'h3F98};
        exp_e = '{8'h78, rnd_e, rnd_e, rnd_e, rnd_e, rnd_e, rnd_e, rnd_e};
        send_block("round");
        drain("round", 8, -1, 8'h77);

        vin   = '{16'h3F80, 16'h3880, 16'h3780, 16'h3580, 16'h7FC0, 16'hFF80, 16'h0000, 16'h0000};
        exp_e = '{8'h78, 8'h08, 8'h02, 8'h00, 8'h7F, 8'hFE, 8'h00, 8'h00};
        send_block("special");
        drain("special", 8, -1, 8'h77);

        vin   = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};
        exp_e = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
        send_block("negzero");
        drain("negzero", 8, -1, 8'h00);

        // Distinct elements so a skipped or repeated handshake is visible.
        vin   = '{16'h3F80, 16'h3FC0, 16'h4000, 16'h4040, 16'h3F00, 16'h3F40, 16'h3FA0, 16'h3E80};
        exp_e = '{8'h70, 8'h74, 8'h78, 8'h7C, 8'h68, 8'h6C, 8'h72, 8'h60};
        send_block("bp");
        drain("bp", 8, 3, 8'h78);

        send_block("clr");
        drain("clr", 5, -1, 8'h78);
        chk("clr_elem5", out_elem, 8'h6C);
        clear     = 1'b1;
        out_ready = 1'b1;
        step();
        clear     = 1'b0;
        out_ready = 1'b0;
        chk("clr_vld", {7'd0, out_valid}, 8'd0);
        chk("clr_rdy", {7'd0, in_ready}, 8'd1);
        // A stale emax from the aborted block would give scale 0x78 here.
        vin   = '{16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80, 16'h3F80};
        exp_e = '{8'h78, 8'h78, 8'h78, 8'h78, 8'h78, 8'h78, 8'h78, 8'h78};
        send_block("after_clr");
        drain("after_clr", 8, -1, 8'h77);

        push(16'h4040);
        push(16'h4040);
        push(16'h4040);
        rst_n = 1'b0;
        #3;
        check_reset_values("midrst");
        step();
        rst_n = 1'b1;
        step();
        send_block("after_rst");
        drain("after_rst", 8, -1, 8'h77);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
